speed_pulse_gen: RTL and testbench



---
 rtl/speed_pulse_if.sv | 19 +
 rtl/speed_pulse_gen.sv | 81 ++++++++
 tb/tb_speed_pulse_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/speed_pulse_if.sv
// speed_pulse_if: button/crash controls in, speed and travel tick out
interface speed_pulse_if;
  logic       run_en;
  logic       up_is_pressed;
  logic       enter_is_pressed;
  logic       crash;
  logic       slow_pulse;
  logic [3:0] speed;
  logic       player_move;
  logic       crashed;
  modport master (
    output run_en, up_is_pressed, enter_is_pressed, crash,
    input  slow_pulse, speed, player_move, crashed
  );
  modport slave (
    input  run_en, up_is_pressed, enter_is_pressed, crash,
    output slow_pulse, speed, player_move, crashed
  );
endinterface

// File: rtl/speed_pulse_gen.sv
// speed_pulse_gen: ramps speed from buttons, turns it into a travel tick, stalls on crash
module speed_pulse_gen #(
  parameter int PULSE_DIV    = 2_500_000,
  parameter int RAMP_CYCLES  = 6_250_000,
  parameter int MAX_SPEED    = 8,
  parameter int TURBO_SPEED  = 12,
  parameter int CRASH_CYCLES = 25_000_000
) (
  input logic          clk,
  input logic          resetN,
  speed_pulse_if.slave bus
);
  localparam int RW = RAMP_CYCLES > 1 ? $clog2(RAMP_CYCLES) : 1;
  localparam int CW = CRASH_CYCLES > 1 ? $clog2(CRASH_CYCLES) : 1;
  localparam logic [31:0] DIV = 32'(PULSE_DIV);
  typedef enum logic {DRIVE, CRASH} state_t;
  state_t        state_q, state_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [CW-1:0] cc_q, cc_d;
  logic [31:0]   acc_q, acc_d, sum;
  logic [3:0]    speed_q, speed_d;
  logic          pulse_q, pulse_d, move_q, move_d;
  logic          wrap, inc, dec;
  // Enter never pulls speed down; otherwise speed drifts toward the active ceiling
  assign wrap = ramp_q == RW'(RAMP_CYCLES - 1);
  assign inc  = (bus.enter_is_pressed && speed_q < 4'(TURBO_SPEED)) ||
                (bus.up_is_pressed && speed_q < 4'(MAX_SPEED));
  assign dec  = !bus.enter_is_pressed &&
                ((bus.up_is_pressed && speed_q > 4'(MAX_SPEED)) ||
                 (!bus.up_is_pressed && speed_q != 4'd0));
  assign sum  = acc_q + 32'(speed_q);
  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    cc_d    = cc_q;
    acc_d   = acc_q;
    speed_d = speed_q;
    pulse_d = 1'b0;
    if (bus.run_en) begin
      if (state_q == CRASH) begin
        state_d = cc_q == CW'(CRASH_CYCLES - 1) ? DRIVE : CRASH;
        cc_d    = cc_q == CW'(CRASH_CYCLES - 1) ? '0 : cc_q + 1'b1;
      end else if (bus.crash) begin
        state_d = CRASH;
        ramp_d  = '0;
        cc_d    = '0;
        acc_d   = '0;
        speed_d = '0;
      end else begin
        ramp_d  = wrap ? '0 : ramp_q + 1'b1;
        speed_d = !wrap ? speed_q : inc ? speed_q + 4'd1 : dec ? speed_q - 4'd1 : speed_q;
        pulse_d = sum >= DIV;
        acc_d   = pulse_d ? sum - DIV : sum;
      end
    end
    move_d = speed_d != 4'd0;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= DRIVE;
      ramp_q  <= '0;
      cc_q    <= '0;
      acc_q   <= '0;
      speed_q <= '0;
      pulse_q <= 1'b0;
      move_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      cc_q    <= cc_d;
      acc_q   <= acc_d;
      speed_q <= speed_d;
      pulse_q <= pulse_d;
      move_q  <= move_d;
    end
  end
  assign bus.slow_pulse  = pulse_q;
  assign bus.speed       = speed_q;
  assign bus.player_move = move_q;
  assign bus.crashed     = state_q == CRASH;
endmodule

// File: tb/tb_speed_pulse_gen.sv
// tb_speed_pulse_gen: table vectors, directed corner sequences and random stimulus vs a reference model
module tb_speed_pulse_gen;
  localparam int PD = 8, RC = 4, MS = 4, TS = 6, CC = 10;
  typedef struct {
    bit r, u, e, c;
    int spd;
    bit pls;
  } vec_t;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int errors = 0, checks = 0;
  int m_speed, m_acc, m_phase, m_stall;
  bit m_pulse;
  vec_t tbl[20];
  speed_pulse_if bus();
  speed_pulse_gen #(
    .PULSE_DIV(PD), .RAMP_CYCLES(RC), .MAX_SPEED(MS), .TURBO_SPEED(TS), .CRASH_CYCLES(CC)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_speed = 0; m_acc = 0; m_phase = 0; m_stall = 0; m_pulse = 0;
  endtask
  // speed drifts one step per ramp period toward the ceiling of the held button
  task automatic model_step(input bit r, input bit u, input bit e, input bit c);
    int ceil_v;
    m_pulse = 0;
    if (!r) return;
    if (m_stall > 0) begin
      m_stall--;
      return;
    end
    if (c) begin
      m_stall = CC; m_speed = 0; m_acc = 0; m_phase = 0;
      return;
    end
    m_acc += m_speed;
    if (m_acc >= PD) begin
      m_acc -= PD;
      m_pulse = 1;
    end
    m_phase = (m_phase + 1) % RC;
    if (m_phase == 0) begin
      ceil_v = e ? TS : u ? MS : 0;
      if (m_speed < ceil_v) m_speed++;
      else if (m_speed > ceil_v && !e) m_speed--;
    end
  endtask
  task automatic cycle(input bit r, input bit u, input bit e, input bit c);
    bus.run_en = r; bus.up_is_pressed = u; bus.enter_is_pressed = e; bus.crash = c;
    @(posedge clk);
    model_step(r, u, e, c);
    #1;
    chk("speed", bus.speed, m_speed);
    chk("slow_pulse", bus.slow_pulse, m_pulse);
    chk("player_move", bus.player_move, m_speed != 0);
    chk("crashed", bus.crashed, m_stall > 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_speed"}, bus.speed, 0);
    chk({tag, "_pulse"}, bus.slow_pulse, 0);
    chk({tag, "_move"}, bus.player_move, 0);
    chk({tag, "_crashed"}, bus.crashed, 0);
  endtask
  initial begin
    int n, b2b;
    bit prev;
    for (int k = 1; k <= 20; k++)
      tbl[k-1] = '{1, 1, 0, 0, (k / 4 > 4) ? 4 : k / 4,
                   (k == 10 || k == 14 || k == 16 || k == 18 || k == 20)};
    bus.run_en = 0; bus.up_is_pressed = 0; bus.enter_is_pressed = 0; bus.crash = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].r, tbl[i].u, tbl[i].e, tbl[i].c);
      chk("tbl_speed", bus.speed, tbl[i].spd);
      chk("tbl_pulse", bus.slow_pulse, tbl[i].pls);
      chk("tbl_move", bus.player_move, tbl[i].spd != 0);
    end
    n = 0; b2b = 0; prev = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1, 1, 0, 0);
      n += bus.slow_pulse;
      if (prev && bus.slow_pulse) b2b++;
      prev = bus.slow_pulse;
    end
    chk("pulses_at_4", n, 32);
    chk("back_to_back", b2b, 0);
    repeat (8) cycle(1, 1, 1, 0);
    chk("turbo_speed", bus.speed, 6);
    repeat (8) cycle(1, 1, 0, 0);
    chk("turbo_release", bus.speed, 4);
    repeat (16) cycle(1, 0, 0, 0);
    chk("coast_speed", bus.speed, 0);
    chk("coast_move", bus.player_move, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0);
      n += bus.slow_pulse;
    end
    chk("coast_pulses", n, 0);
    repeat (16) cycle(1, 1, 0, 0);
    repeat (8) cycle(1, 1, 1, 0);
    chk("pre_crash_speed", bus.speed, 6);
    cycle(1, 1, 1, 1);
    chk("crash_crashed", bus.crashed, 1);
    chk("crash_speed", bus.speed, 0);
    n = 1; b2b = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 1, i == 2);
      b2b += bus.slow_pulse;
      if (!bus.crashed) break;
      n++;
    end
    chk("stall_len", n, CC);
    chk("stall_pulses", b2b, 0);
    repeat (4) cycle(1, 1, 0, 0);
    chk("reramp_speed", bus.speed, 1);
    repeat (12) cycle(1, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0, i == 5);
      n += bus.slow_pulse;
    end
    chk("frozen_pulses", n, 0);
    chk("frozen_speed", bus.speed, 4);
    chk("frozen_crashed", bus.crashed, 0);
    repeat (2) cycle(1, 1, 0, 0);
    #3;
    resetN = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    repeat (600)
      cycle($urandom_range(9) != 0, $urandom_range(9) < 6,
            $urandom_range(9) < 3, $urandom_range(39) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
